// File: rtl/coin_acceptor.sv
// coin_acceptor: conditions the raw coin sensors and feeds clean coin pulses to vending_machine.
// Each sensor line is synchronised, debounced and jam-monitored. Rising edges are queued in a
// small FIFO, and an IDLE/PULSE/GAP FSM meters the queued coins out.
// Optional feature: define COIN_TOTAL_EN to add the saturating credit_total output.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 2,
   parameter int FIFO_DEPTH      = 4,
   parameter int JAM_CYCLES      = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sense_1,
   input  logic                          sense_2,
   input  logic                          accept_en,
   output logic                          coin_1,
   output logic                          coin_2,
   output logic                          coin_reject,
   output logic                          jam,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef COIN_TOTAL_EN
   ,
   output logic [7:0]                    credit_total
`endif
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int JW  = $clog2(JAM_CYCLES + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int GW  = $clog2(GAP_CYCLES + 2);

   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [JW-1:0]  JAM_LAST = JW'(JAM_CYCLES - 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
   localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} state_t;

   // Reset: asserts asynchronously, releases on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   // Assert immediately with reset, release through two flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // Per-channel conditioning (bit 0 = Rs1 sensor, bit 1 = Rs2 sensor).
   logic [1:0] w_sense;
   logic [1:0] w_evt;
   logic [1:0] w_jam;
   assign w_sense = {sense_2, sense_1};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ch
         logic [1:0]     r_sync;
         logic [DBW-1:0] r_db_cnt;
         logic           r_deb;
         logic           r_deb_d;
         logic [JW-1:0]  r_jam_cnt;
         logic           r_jam;
         logic           r_evt;

         // Synchronise the raw sensor and flip the debounced level after a stable disagreement run.
         always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
               r_sync   <= 2'b00;
               r_db_cnt <= '0;
               r_deb    <= 1'b0;
               r_deb_d  <= 1'b0;
            end else begin
               r_sync  <= {r_sync[0], w_sense[gi]};
               r_deb_d <= r_deb;
               if (r_sync[1] != r_deb) begin
                  if (r_db_cnt == DB_LAST) begin
                     r_deb    <= r_sync[1];
                     r_db_cnt <= '0;
                  end else begin
                     r_db_cnt <= r_db_cnt + DBW'(1);
                  end
               end else begin
                  r_db_cnt <= '0;
               end
            end
         end

         // Jam detection on a long debounced-high run; the rising-edge event is registered here too.
         always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
               r_jam_cnt <= '0;
               r_jam     <= 1'b0;
               r_evt     <= 1'b0;
            end else begin
               r_evt <= r_deb & ~r_deb_d & ~r_jam;
               if (!r_deb) begin
                  r_jam_cnt <= '0;
                  r_jam     <= 1'b0;
               end else if (!r_jam) begin
                  if (r_jam_cnt == JAM_LAST) r_jam <= 1'b1;
                  else                       r_jam_cnt <= r_jam_cnt + JW'(1);
               end
            end
         end

         assign w_evt[gi] = r_evt;
         assign w_jam[gi] = r_jam;
      end
   endgenerate

   // Arbitration between the two event sources and the FIFO.
   state_t          r_state;
   state_t          w_state_next;
   logic [GW-1:0]   r_gap_cnt;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_reject;
   logic            r_cur;
   logic            r_mem [FIFO_DEPTH];
   logic            w_one;
   logic            w_both;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;

   assign w_one   = w_evt[0] ^ w_evt[1];
   assign w_both  = w_evt[0] & w_evt[1];
   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);
   assign w_pop   = (r_state == ST_IDLE) && !w_empty && accept_en;
   assign w_push  = w_one && (!w_full || w_pop);
   assign w_drop  = w_both || (w_one && w_full && !w_pop);

   // Coin storage: entry 0 = Rs1, 1 = Rs2; contents are not reset, only the pointers.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_evt[1];
   end

   // Registered read of the head entry when the FSM pops it.
   always_ff @(posedge clk) begin
      if (w_pop) r_cur <= r_mem[r_rd_ptr];
   end

   // Pointer, occupancy and reject-pulse bookkeeping.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_reject <= 1'b0;
      end else begin
         r_reject <= w_drop;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state register and gap timer.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= ST_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_PULSE)    r_gap_cnt <= '0;
         else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      end
   end

   // FSM next state; accept_en only matters while idle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_pop) w_state_next = ST_PULSE;
         ST_PULSE: w_state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:   if (r_gap_cnt == GAP_LAST) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: exactly one coin line during PULSE, selected by the popped entry.
   always_comb begin
      coin_1 = 1'b0;
      coin_2 = 1'b0;
      if (r_state == ST_PULSE) begin
         coin_1 = ~r_cur;
         coin_2 = r_cur;
      end
   end

   assign coin_reject = r_reject;
   assign jam         = |w_jam;
   assign fifo_count  = r_count;

`ifdef COIN_TOTAL_EN
   logic [7:0] r_credit;

   // Saturating running total of forwarded coin value.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_credit <= 8'd0;
      end else if (r_state == ST_PULSE) begin
         if (r_cur) r_credit <= (r_credit >= 8'd254) ? 8'd255 : r_credit + 8'd2;
         else       r_credit <= (r_credit == 8'd255) ? 8'd255 : r_credit + 8'd1;
      end
   end
   assign credit_total = r_credit;
`endif

endmodule
